knap_search: RTL and testbench
==============================

KNAP_SEARCH -- requirements
Module: knap_search

Parameters
REQ-001 The block SHALL provide parameter N_ITEMS, default 5, giving the number of items; the candidate space is 2^N_ITEMS subsets.
REQ-002 The block SHALL provide parameter ITEM_W, default 8, giving the width of each item value and weight.
REQ-003 The block SHALL provide parameter SUM_W, default 16, giving the width of totals and thresholds; SUM_W >= ITEM_W + clog2(N_ITEMS) is required.

Interface
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1), rising-edge clock; rst (input, 1), synchronous active-high reset.
REQ-005 start (input, 1) SHALL request a search.
REQ-006 abort (input, 1) SHALL cancel a running search.
REQ-007 values (input, N_ITEMS*ITEM_W) SHALL carry the item values; item i occupies bits [i*ITEM_W +: ITEM_W].
REQ-008 weights (input, N_ITEMS*ITEM_W) SHALL carry the item weights, packed as for values.
REQ-009 min_value (input, SUM_W) SHALL carry the minimum acceptable total value.
REQ-010 max_weight (input, SUM_W) SHALL carry the maximum acceptable total weight.
REQ-011 busy (output, 1) SHALL be high while the block is scanning.
REQ-012 done (output, 1) SHALL be a one-cycle pulse indicating completion.
REQ-013 found (output, 1) SHALL indicate that at least one valid subset exists.
REQ-014 best_sel (output, N_ITEMS) SHALL carry the best subset; bit i set means item i is selected.
REQ-015 best_value and best_weight (outputs, SUM_W each) SHALL carry the totals of best_sel.
REQ-016 valid_count (output, N_ITEMS+1) SHALL carry the number of valid subsets.

Function
REQ-017 The block SHALL implement FSM states IDLE, SCAN and DONE.
REQ-018 In IDLE, start=1 SHALL capture values, weights, min_value and max_weight into internal registers, clear cand, best and count, and move to SCAN.
REQ-019 Input changes after that capture SHALL have no effect on the search.
REQ-020 In SCAN, the block SHALL evaluate one candidate per cycle, cand = 0 .. 2^N_ITEMS-1 ascending.
REQ-021 Per candidate, tv SHALL be the sum of the captured values of selected items and tw the sum of selected weights, both zero-extended to SUM_W.
REQ-022 A candidate SHALL be valid when tv >= min_value and tw <= max_weight, using unsigned comparison; both bounds are inclusive.
REQ-023 For each valid candidate, valid_count SHALL increment by 1.
REQ-024 For a valid candidate, best SHALL be replaced only if no best exists yet or tv > best_value (strict); on a tie the lower cand index is kept.
REQ-025 After the candidate 2^N_ITEMS-1 cycle, the FSM SHALL go to DONE; cand wraps to 0 and is not re-evaluated.
REQ-026 The block SHALL hold DONE for exactly 1 cycle, with done=1, then return to IDLE.
REQ-027 Latency SHALL be: start sampled at edge k; busy=1 from cycle k+1 through k+2^N_ITEMS; done=1 in cycle k+2^N_ITEMS+1 (cycle 33 for N_ITEMS=5).
REQ-028 found SHALL equal (valid_count != 0).
REQ-029 Results (found, best_*, valid_count) SHALL update only during SCAN and SHALL hold stable from DONE until the next accepted start.
REQ-030 If no subset is valid, the block SHALL report found=0, best_sel=0, best_value=0, best_weight=0 and valid_count=0.
REQ-031 start SHALL be ignored while in SCAN or DONE; no queuing is performed.
REQ-032 abort=1 in SCAN SHALL return the FSM to IDLE next cycle with no done pulse; results are cleared to zero.
REQ-033 If abort and start are both high in IDLE, abort SHALL win and the search is not started.
REQ-034 abort SHALL be ignored in IDLE and DONE.
REQ-035 The datapath SHALL be registered: totals and the compare are combinational from cand, and update of best and count happens on the same edge, so no extra pipeline latency is permitted.

Reset
REQ-036 rst=1 on any edge SHALL force IDLE, including mid-scan, and reset all outputs: busy=0, done=0, found=0, best_sel=0, best_value=0, best_weight=0, valid_count=0.
REQ-037 rst SHALL take priority over start and abort.
REQ-038 The first start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-039 Baseline: values(i=0..4)=4,2,2,1,10; weights=12,1,2,1,4; min_value=15; max_weight=16; start pulse -> done at k+33 with found=1, best_sel=5'b11110, best_value=15, best_weight=8, valid_count=1.
REQ-040 Same items with max_weight=17 -> valid_count=3 (5'b10011, 5'b11001, 5'b11110); best_sel=5'b10011, best_value=16, best_weight=17.
REQ-041 Same items with min_value=30 -> found=0, best_sel=0, best_value=0, valid_count=0; done still pulses at k+33.
REQ-042 Tie case: all values=1, all weights=1, min_value=1, max_weight=1 -> valid_count=5, best_sel=5'b00001 (lowest index kept), best_value=1, best_weight=1.
REQ-043 Second start issued at k+10, plus changes to values mid-scan -> both ignored; results identical to REQ-039; done pulses exactly once.
REQ-044 abort at k+15, or rst at k+15 -> IDLE next cycle, busy=0, no done, results zero; a fresh start then reproduces REQ-039.

Source files
------------

// File: rtl/knap_search.sv
// Exhaustive 0/1 knapsack search: one subset per cycle, keeping the best-valued
// subset that meets the value floor and weight ceiling, plus a count of valid subsets.
module knap_search #(
  parameter int N_ITEMS = 5,
  parameter int ITEM_W  = 8,
  parameter int SUM_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_ITEMS*ITEM_W-1:0]   values,
  input  logic [N_ITEMS*ITEM_W-1:0]   weights,
  input  logic [SUM_W-1:0]            min_value,
  input  logic [SUM_W-1:0]            max_weight,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [N_ITEMS-1:0]          best_sel,
  output logic [SUM_W-1:0]            best_value,
  output logic [SUM_W-1:0]            best_weight,
  output logic [N_ITEMS:0]            valid_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                  state;
  logic [N_ITEMS-1:0]          cand;
  logic [N_ITEMS*ITEM_W-1:0]   val_r;
  logic [N_ITEMS*ITEM_W-1:0]   wt_r;
  logic [SUM_W-1:0]            minv_r;
  logic [SUM_W-1:0]            maxw_r;
  logic [SUM_W-1:0]            tv;
  logic [SUM_W-1:0]            tw;
  logic                        cand_ok;
  logic                        take;

  always_comb begin
    tv = '0;
    tw = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (cand[i]) begin
        tv = tv + SUM_W'(val_r[i*ITEM_W +: ITEM_W]);
        tw = tw + SUM_W'(wt_r[i*ITEM_W +: ITEM_W]);
      end
    end
  end

  // An empty count means no best yet, so a zero-valued first hit still registers.
  assign cand_ok = (tv >= minv_r) && (tw <= maxw_r);
  assign take    = cand_ok && ((valid_count == '0) || (tv > best_value));

  assign busy  = (state == SCAN);
  assign done  = (state == DONE);
  assign found = (valid_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      val_r       <= '0;
      wt_r        <= '0;
      minv_r      <= '0;
      maxw_r      <= '0;
      best_sel    <= '0;
      best_value  <= '0;
      best_weight <= '0;
      valid_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            val_r       <= values;
            wt_r        <= weights;
            minv_r      <= min_value;
            maxw_r      <= max_weight;
            cand        <= '0;
            best_sel    <= '0;
            best_value  <= '0;
            best_weight <= '0;
            valid_count <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            cand        <= '0;
            best_sel    <= '0;
            best_value  <= '0;
            best_weight <= '0;
            valid_count <= '0;
            state       <= IDLE;
          end else begin
            if (cand_ok) valid_count <= valid_count + (N_ITEMS+1)'(1);
            if (take) begin
              best_sel    <= cand;
              best_value  <= tv;
              best_weight <= tw;
            end
            cand <= cand + N_ITEMS'(1);
            if (cand == '1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knap_search.sv
// Bench for knap_search: directed scenarios plus random item sets checked
// against a brute-force subset model.
module tb_knap_search;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [39:0] values, weights;
  logic [15:0] min_value, max_weight;
  logic        busy, done, found;
  logic [4:0]  best_sel;
  logic [15:0] best_value, best_weight;
  logic [5:0]  valid_count;

  int checks = 0;
  int errors = 0;

  logic        exp_found;
  logic [4:0]  exp_sel;
  int          exp_bv, exp_bw, exp_cnt;

  knap_search #(.N_ITEMS(5), .ITEM_W(8), .SUM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .values(values), .weights(weights),
    .min_value(min_value), .max_weight(max_weight),
    .busy(busy), .done(done), .found(found),
    .best_sel(best_sel), .best_value(best_value), .best_weight(best_weight),
    .valid_count(valid_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [39:0] v, input logic [39:0] w,
                       input logic [15:0] mn, input logic [15:0] mx);
    exp_cnt = 0; exp_sel = '0; exp_bv = 0; exp_bw = 0;
    for (int s = 0; s < 32; s++) begin
      int sv, sw;
      sv = 0; sw = 0;
      for (int i = 0; i < 5; i++)
        if (((s >> i) & 1) == 1) begin
          sv += int'(v[i*8 +: 8]);
          sw += int'(w[i*8 +: 8]);
        end
      if (sv >= int'(mn) && sw <= int'(mx)) begin
        if (exp_cnt == 0 || sv > exp_bv) begin
          exp_sel = 5'(s); exp_bv = sv; exp_bw = sw;
        end
        exp_cnt++;
      end
    end
    exp_found = (exp_cnt != 0);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_found"}, 32'(found), 32'(exp_found));
    check({tag, "_sel"},   32'(best_sel), 32'(exp_sel));
    check({tag, "_bv"},    32'(best_value), exp_bv);
    check({tag, "_bw"},    32'(best_weight), exp_bw);
    check({tag, "_cnt"},   32'(valid_count), exp_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_found"}, 32'(found), 0);
    check({tag, "_sel"},   32'(best_sel), 0);
    check({tag, "_bv"},    32'(best_value), 0);
    check({tag, "_bw"},    32'(best_weight), 0);
    check({tag, "_cnt"},   32'(valid_count), 0);
  endtask

  // Called just after a rising edge; start is sampled at the next edge (edge k).
  // mode: 0 plain, 1 restart+input churn mid-scan, 2 abort at k+15, 3 rst at k+15,
  // 4 start held during DONE.
  task automatic do_search(input logic [39:0] v, input logic [39:0] w,
                           input logic [15:0] mn, input logic [15:0] mx, input int mode);
    values = v; weights = w; min_value = mn; max_weight = mx;
    model(v, w, mn, mx);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check("busy_scan", 32'(busy), 1);
      check("done_early", 32'(done), 0);
      if (mode == 1 && c == 10) begin
        start = 1'b1;
        values = {$urandom, 8'($urandom)};
        weights = {$urandom, 8'($urandom)};
        min_value = 16'($urandom);
        max_weight = 16'($urandom);
      end
      if (mode == 1 && c == 11) start = 1'b0;
      if ((mode == 2 || mode == 3) && c == 15) begin
        if (mode == 2) abort = 1'b1; else rst = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; rst = 1'b0;
        check_zero(mode == 2 ? "abort" : "midrst");
        for (int j = 0; j < 30; j++) begin
          @(posedge clk); #1;
          check("cancel_nodone", 32'(done | busy), 0);
        end
        return;
      end
      @(posedge clk); #1;
    end
    check("done_pulse", 32'(done), 1);
    check("busy_done", 32'(busy), 0);
    check_results("res");
    if (mode == 4) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_once", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("idle_busy2", 32'(busy), 0);
    check_results("hold");
  endtask

  localparam logic [39:0] BV = {8'd10, 8'd1, 8'd2, 8'd2, 8'd4};
  localparam logic [39:0] BW = {8'd4, 8'd1, 8'd2, 8'd1, 8'd12};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    values = '0; weights = '0; min_value = '0; max_weight = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Baseline, started in the first cycle after reset release
    do_search(BV, BW, 16'd15, 16'd16, 0);
    check("base_sel", 32'(best_sel), 32'(5'b11110));
    check("base_bv", 32'(best_value), 15);
    check("base_bw", 32'(best_weight), 8);
    check("base_cnt", 32'(valid_count), 1);

    do_search(BV, BW, 16'd15, 16'd17, 0);
    check("w17_sel", 32'(best_sel), 32'(5'b10011));
    check("w17_cnt", 32'(valid_count), 3);

    do_search(BV, BW, 16'd30, 16'd16, 0);
    check("none_found", 32'(found), 0);

    do_search({5{8'd1}}, {5{8'd1}}, 16'd1, 16'd1, 0);
    check("tie_sel", 32'(best_sel), 32'(5'b00001));
    check("tie_cnt", 32'(valid_count), 5);

    do_search(BV, BW, 16'd15, 16'd16, 1);
    check("churn_sel", 32'(best_sel), 32'(5'b11110));

    do_search(BV, BW, 16'd15, 16'd16, 2);
    do_search(BV, BW, 16'd15, 16'd16, 0);
    check("post_abort_sel", 32'(best_sel), 32'(5'b11110));

    do_search(BV, BW, 16'd15, 16'd16, 3);
    do_search(BV, BW, 16'd15, 16'd16, 4);
    check("post_rst_sel", 32'(best_sel), 32'(5'b11110));

    // abort beats start in IDLE; results from previous run are kept
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    check_results("abort_idle");
    @(posedge clk); #1;
    check("abort_start_busy2", 32'(busy), 0);

    // zero bounds: the empty subset is valid
    do_search(BV, BW, 16'd0, 16'd0, 0);
    check("empty_cnt", 32'(valid_count), 1);

    for (int t = 0; t < 8; t++) begin
      logic [39:0] rv, rw;
      logic [15:0] mn, mx;
      rv = {$urandom, 8'($urandom)};
      rw = {$urandom, 8'($urandom)};
      if (t % 2 == 1) begin
        rv = rv & {5{8'h03}};
        rw = rw & {5{8'h03}};
        mn = 16'($urandom_range(0, 8));
        mx = 16'($urandom_range(0, 10));
      end else begin
        mn = 16'($urandom_range(0, 700));
        mx = 16'($urandom_range(0, 900));
      end
      if (t == 6) mx = 16'hFFFF;
      do_search(rv, rw, mn, mx, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
